hazard_fwd_unit: RTL
====================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised data-hazard unit for the in-order RV32I pipeline; successor to the 2-source forwarding logic.
//  Selects ALU operand sources from NUM_FWD later stages with nearest-stage priority.
//  Detects load-use hazards and holds IF/ID for LOAD_LAT cycles via a stall FSM; inserts EX bubbles.
//  Freezes the whole pipe on data-memory wait. Sits beside the ID/EX pipeline register, driving operand muxes and stage enables.
// PARAMETERS
//  WIDTH     32  instruction word width
//  NUM_FWD   2   forwarding sources; index 0 = MEM (nearest), 1 = WB, 2.. = later write stages
//  LOAD_LAT  1   load-use stall cycles (>=1); >1 for multi-cycle data memory
//  SELW      $clog2(NUM_FWD+1)  select width (localparam, derived)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            async reset, active-high
//  instr_id     in   WIDTH        instruction in ID
//  instr_ex     in   WIDTH        instruction in EX (rs1 [19:15], rs2 [24:20], rd [11:7])
//  mem_read_ex  in   1            EX instruction is a load
//  rd_fwd       in   NUM_FWD*5    rd of each forwarding stage, source k at [5k+4:5k]
//  regw_fwd     in   NUM_FWD      register-write enable of each forwarding stage
//  flush_id     in   1            taken branch/jump squashes the ID instruction this cycle
//  mem_wait     in   1            data memory not ready; whole pipeline must hold
//  forward_a    out  SELW         rs1 operand select: 0 = regfile, k+1 = source k
//  forward_b    out  SELW         rs2 operand select, same encoding
//  stall_pc     out  1            hold PC
//  stall_id     out  1            hold IF/ID register
//  bubble_ex    out  1            load NOP into ID/EX register
//  freeze       out  1            hold all pipeline registers (mem_wait)
// BEHAVIOUR
//  Forwarding is combinational.
//   - forward_a = k+1 for the lowest k with regw_fwd[k] && rd_fwd[k]!=0 && rd_fwd[k]==rs1_ex; else 0. forward_b uses rs2_ex.
//   - The select is a binary code, never a multi-hot vector; the nearest stage always wins.
//  Use decode of instr_id:
//   - rs1 unused for LUI, AUIPC, JAL.
//   - rs2 used only for OP, STORE, BRANCH.
//   - x0 never hazards.
//  hazard = mem_read_ex && rd_ex!=0 && rd_ex matches a used rs of instr_id.
//  FSM IDLE/STALL; cnt is $clog2(LOAD_LAT+1) bits.
//   - IDLE: hazard && !flush_id -> stall_pc=stall_id=bubble_ex=1 in the same cycle.
//     Next: if LOAD_LAT>1 go to STALL with cnt=LOAD_LAT-1; else stay IDLE.
//   - STALL: stall_pc=stall_id=bubble_ex=1; cnt decrements each cycle; cnt==1 -> IDLE next.
//   - flush_id (either state): stall/bubble outputs=0 that cycle; FSM -> IDLE, cnt=0.
//  mem_wait (highest priority):
//   - freeze=stall_pc=stall_id=1, bubble_ex=0.
//   - FSM and cnt hold their values; new hazards are not started.
//  Reset: FSM=IDLE, cnt=0. While rst is high, stall_pc=stall_id=bubble_ex=freeze=0.
//   - forward_a/b are not gated by reset.
//   - Reset mid-stall aborts the stall immediately.
//  Back-to-back load-use after a stall ends is detected in the IDLE cycle following STALL.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds out ports perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
//   - perf_stall_cnt increments on each cycle with stall_id && !freeze.
//   - perf_fwd_cnt increments on each cycle with forward_a!=0 or forward_b!=0 (once per cycle).
//   - Both counters wrap at 2^32 and reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package rv_pkg: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_STORE, OP_BRANCH), FSM state encoding, field-slice localparams.
//  Sub-module fwd_select (one instance per operand): rs, rd_fwd, regw_fwd -> priority-encoded SELW select.
//  FSM, use decode and the optional counters live in the top module.
// TESTING
//  1. rs1_ex=5, rd_fwd={WB:5, MEM:5}, regw={1,1} -> forward_a=1 (MEM priority); MEM regw=0 -> forward_a=2.
//  2. rd_fwd MEM=0 with regw=1, rs2_ex=0 -> forward_b=0 (x0 never forwarded).
//  3. LOAD_LAT=3: lw x7 in EX, add x1,x7,x2 in ID -> stall_pc/stall_id/bubble_ex high exactly 3 cycles, then low.
//  4. lw x7 in EX, lui x7 / addi x1,x3,1 in ID -> no stall (unused or non-matching rs).
//  5. LOAD_LAT=3: mem_wait pulsed 2 cycles during STALL -> freeze=1, bubble_ex=0, cnt held; total stall cycles = 5.
//  6. flush_id in the 2nd stall cycle -> stalls drop that cycle, FSM in IDLE next. rst mid-STALL -> all stall outputs 0, FSM IDLE.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32I opcodes, instruction field positions, stall FSM
//                state encoding and register-use decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int c_OPC_LSB = 0;
    localparam int c_OPC_W   = 7;
    localparam int c_RD_LSB  = 7;
    localparam int c_RS1_LSB = 15;
    localparam int c_RS2_LSB = 20;
    localparam int c_REG_W   = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    function automatic logic uses_rs1(input logic [c_OPC_W-1:0] opc);
        return !((opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [c_OPC_W-1:0] opc);
        return (opc == OP_OP) || (opc == OP_STORE) || (opc == OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Priority-encodes one ALU operand source; lowest stage index
//                (nearest stage) wins, x0 is never forwarded.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_select
    import rv_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SELW    = $clog2(NUM_FWD + 1)
) (
    input  logic [c_REG_W-1:0]         i_rs,
    input  logic [NUM_FWD*c_REG_W-1:0] i_rd_fwd,
    input  logic [NUM_FWD-1:0]         i_regw_fwd,
    output logic [SELW-1:0]            o_sel
);

    // Walk from the farthest stage inward so the nearest match overwrites.
    always_comb begin
        o_sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_regw_fwd[k] && (i_rd_fwd[k*c_REG_W +: c_REG_W] != '0) &&
                (i_rd_fwd[k*c_REG_W +: c_REG_W] == i_rs)) begin
                o_sel = SELW'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Operand forwarding select, load-use stall FSM and memory-wait
//                freeze for the in-order RV32I pipeline.
//                Optional macro HAZARD_PERF_EN adds stall/forward counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
    import rv_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int NUM_FWD  = 2,
    parameter  int LOAD_LAT = 1,
    localparam int SELW     = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           instr_id,
    input  logic [WIDTH-1:0]           instr_ex,
    input  logic                       mem_read_ex,
    input  logic [NUM_FWD*c_REG_W-1:0] rd_fwd,
    input  logic [NUM_FWD-1:0]         regw_fwd,
    input  logic                       flush_id,
    input  logic                       mem_wait,
    output logic [SELW-1:0]            forward_a,
    output logic [SELW-1:0]            forward_b,
    output logic                       stall_pc,
    output logic                       stall_id,
    output logic                       bubble_ex,
    output logic                       freeze
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_fwd_cnt
`endif
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    logic [c_REG_W-1:0] w_rs1_ex, w_rs2_ex, w_rd_ex, w_rs1_id, w_rs2_id;
    logic [c_OPC_W-1:0] w_opc_id;
    logic               w_hazard;
    logic               w_stall, w_bubble, w_freeze;
    stall_state_t       r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               w_unused_bits;

    assign w_rs1_ex = instr_ex[c_RS1_LSB +: c_REG_W];
    assign w_rs2_ex = instr_ex[c_RS2_LSB +: c_REG_W];
    assign w_rd_ex  = instr_ex[c_RD_LSB  +: c_REG_W];
    assign w_rs1_id = instr_id[c_RS1_LSB +: c_REG_W];
    assign w_rs2_id = instr_id[c_RS2_LSB +: c_REG_W];
    assign w_opc_id = instr_id[c_OPC_LSB +: c_OPC_W];

    assign w_unused_bits = ^{instr_id[WIDTH-1:25], instr_id[14:7],
                             instr_ex[WIDTH-1:25], instr_ex[14:12], instr_ex[6:0]};

    fwd_select #(.NUM_FWD(NUM_FWD), .SELW(SELW)) u_fwd_a (
        .i_rs       (w_rs1_ex),
        .i_rd_fwd   (rd_fwd),
        .i_regw_fwd (regw_fwd),
        .o_sel      (forward_a)
    );

    fwd_select #(.NUM_FWD(NUM_FWD), .SELW(SELW)) u_fwd_b (
        .i_rs       (w_rs2_ex),
        .i_rd_fwd   (rd_fwd),
        .i_regw_fwd (regw_fwd),
        .o_sel      (forward_b)
    );

    assign w_hazard = mem_read_ex && (w_rd_ex != '0) &&
                      ((uses_rs1(w_opc_id) && (w_rs1_id == w_rd_ex)) ||
                       (uses_rs2(w_opc_id) && (w_rs2_id == w_rd_ex)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // mem_wait outranks flush, which outranks any stall activity.
    always_comb begin
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_freeze    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (mem_wait) begin
            w_freeze = 1'b1;
            w_stall  = 1'b1;
        end else if (flush_id) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hazard) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = ST_STALL;
                            w_cnt_nxt   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                ST_STALL: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_cnt <= CW'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign stall_pc  = w_stall  & ~rst;
    assign stall_id  = w_stall  & ~rst;
    assign bubble_ex = w_bubble & ~rst;
    assign freeze    = w_freeze & ~rst;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall, r_perf_fwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (stall_id && !freeze) r_perf_stall <= r_perf_stall + 32'd1;
            if ((forward_a != '0) || (forward_b != '0)) r_perf_fwd <= r_perf_fwd + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`endif

endmodule
`default_nettype wire
